// File: rtl/temporal_decoder_n.sv
// Temporal decoder: converts first-rising-edge arrival times of N race-logic lines
// into binary stamps per gamma cycle and hands them off over valid/ready.
module temporal_decoder_n #(
    parameter int unsigned NUM_INPUTS        = 4,
    parameter int unsigned GAMMA_CYCLE_WIDTH = 16,
    parameter int unsigned SYNC_STAGES       = 2,
    parameter int unsigned T_W               = $clog2(GAMMA_CYCLE_WIDTH)
) (
    input  logic                           aclk,
    input  logic                           grst_n,
    input  logic [NUM_INPUTS-1:0]          inputs,
    output logic                           gamma_rst,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NUM_INPUTS-1:0]          fired,
    output logic [NUM_INPUTS*T_W-1:0]      times,
    output logic                           overrun
);

    localparam int unsigned N = NUM_INPUTS;
    localparam logic [T_W-1:0] LAST_COUNT = T_W'(GAMMA_CYCLE_WIDTH - 1);
    localparam logic [T_W-1:0] WIN_START  = T_W'(SYNC_STAGES);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    logic [T_W-1:0]                 count_q, count_d;
    logic [SYNC_STAGES-1:0][N-1:0]  sync_q, sync_d;
    logic [N-1:0]                   cf_q, cf_d;
    logic [N-1:0][T_W-1:0]          ct_q, ct_d;

    logic [N-1:0]                   s;
    logic                           in_window;
    logic                           last_cycle;
    logic [T_W-1:0]                 stamp;
    logic [N-1:0]                   cap;
    logic [N-1:0]                   res_fired;
    logic [N-1:0][T_W-1:0]          res_times;

    state_e                         state_q;
    logic [N-1:0]                   fired_q;
    logic [N-1:0][T_W-1:0]          times_q;
    logic                           overrun_q;

    // Gamma-cycle counter; power-of-two length so it wraps naturally.
    assign count_d = count_q + T_W'(1);

    always_ff @(posedge aclk or negedge grst_n) begin
        if (!grst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign gamma_rst = (count_q == '0);

    // Per-line synchronizer chain; stage 0 samples the raw line.
    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = inputs;
        for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    always_ff @(posedge aclk or negedge grst_n) begin
        if (!grst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Capture: first synchronized high in the window, stamped back by the sync latency.
    assign in_window  = (count_q >= WIN_START);
    assign last_cycle = (count_q == LAST_COUNT);
    assign stamp      = count_q - WIN_START;
    assign cap        = s & ~cf_q & {N{in_window}};

    always_comb begin
        res_fired = cf_q | cap;
        res_times = ct_q;
        for (int unsigned i = 0; i < N; i++) begin
            if (cap[i]) begin
                res_times[i] = stamp;
            end
        end
    end

    always_comb begin
        cf_d = res_fired;
        ct_d = res_times;
        if (last_cycle) begin
            cf_d = '0;
            ct_d = '0;
        end
    end

    always_ff @(posedge aclk or negedge grst_n) begin
        if (!grst_n) begin
            cf_q <= '0;
            ct_q <= '0;
        end else begin
            cf_q <= cf_d;
            ct_q <= ct_d;
        end
    end

    // Output handshake FSM; a load arrives only at the end of a gamma cycle.
    always_ff @(posedge aclk or negedge grst_n) begin
        if (!grst_n) begin
            state_q   <= ST_EMPTY;
            fired_q   <= '0;
            times_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            case (state_q)
                ST_EMPTY: begin
                    if (last_cycle) begin
                        fired_q <= res_fired;
                        times_q <= res_times;
                        state_q <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (last_cycle) begin
                        if (out_ready) begin
                            fired_q <= res_fired;
                            times_q <= res_times;
                        end else begin
                            overrun_q <= 1'b1;
                        end
                    end else if (out_ready) begin
                        state_q <= ST_EMPTY;
                    end
                end
                default: state_q <= ST_EMPTY;
            endcase
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign fired     = fired_q;
    assign times     = times_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_temporal_decoder_n.sv
// Scoreboard bench for temporal_decoder_n: expected results are queued per gamma
// cycle from the planned rise times and compared while the DUT presents them.
module tb_temporal_decoder_n;

    localparam int unsigned N   = 4;
    localparam int unsigned G   = 16;
    localparam int unsigned S   = 2;
    localparam int unsigned T_W = 4;

    typedef struct packed {
        logic [N-1:0]     f;
        logic [N*T_W-1:0] t;
    } result_t;

    logic               aclk;
    logic               grst_n;
    logic [N-1:0]       inputs;
    logic               gamma_rst;
    logic               out_valid;
    logic               out_ready;
    logic [N-1:0]       fired;
    logic [N*T_W-1:0]   times;
    logic               overrun;

    int      n_checks;
    int      n_errors;
    int      m_cnt;
    bit      mdl_full;
    bit      exp_ovr;
    result_t pend;
    result_t exp_q[$];

    temporal_decoder_n #(
        .NUM_INPUTS       (N),
        .GAMMA_CYCLE_WIDTH(G),
        .SYNC_STAGES      (S),
        .T_W              (T_W)
    ) dut (
        .aclk     (aclk),
        .grst_n   (grst_n),
        .inputs   (inputs),
        .gamma_rst(gamma_rst),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .fired    (fired),
        .times    (times),
        .overrun  (overrun)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t, cnt=%0d)", tag, act, exp, $time, m_cnt);
        end
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_gamma_rst", 32'(gamma_rst), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_fired",     32'(fired),     32'd0);
        check_eq("rst_times",     32'(times),     32'd0);
        check_eq("rst_overrun",   32'(overrun),   32'd0);
    endtask

    // Asserts reset from a sample point, holds it 3 edges, releases into a count-0 cycle.
    task automatic do_reset();
        grst_n = 1'b0;
        inputs = '0;
        out_ready = 1'b0;
        #1;
        check_reset_outputs();
        repeat (3) @(posedge aclk);
        #1;
        check_reset_outputs();
        exp_q.delete();
        mdl_full = 1'b0;
        exp_ovr  = 1'b0;
        m_cnt    = 0;
        grst_n   = 1'b1;
    endtask

    // One aclk cycle: sample outputs, drive inputs, advance the transaction model.
    task automatic cyc(input logic [N-1:0] in_v, input logic rdy);
        bit load;
        check_eq("gamma_rst", 32'(gamma_rst), 32'(m_cnt == 0));
        check_eq("out_valid", 32'(out_valid), 32'(mdl_full));
        check_eq("overrun",   32'(overrun),   32'(exp_ovr));
        if (mdl_full) begin
            check_eq("fired", 32'(fired), 32'(exp_q[0].f));
            check_eq("times", 32'(times), 32'(exp_q[0].t));
        end
        inputs    = in_v;
        out_ready = rdy;
        load    = (m_cnt == G - 1);
        exp_ovr = 1'b0;
        if (mdl_full && rdy) begin
            exp_q.delete(0);
            mdl_full = 1'b0;
        end
        if (load) begin
            if (mdl_full) begin
                exp_ovr = 1'b1;
            end else begin
                exp_q.push_back(pend);
                mdl_full = 1'b1;
            end
        end
        m_cnt = (m_cnt + 1) % G;
        @(posedge aclk);
        #1;
    endtask

    // One gamma cycle; rN<0 means line never rises, rmask[c] is out_ready during count c.
    task automatic gamma(input int r0, input int r1, input int r2, input int r3,
                         input logic [15:0] rmask);
        int r[N];
        logic [N-1:0] in_v;
        r[0] = r0; r[1] = r1; r[2] = r2; r[3] = r3;
        pend = '0;
        for (int i = 0; i < N; i++) begin
            if (r[i] >= 0 && r[i] <= G - 1 - S) begin
                pend.f[i]         = 1'b1;
                pend.t[i*T_W +: T_W] = T_W'(r[i]);
            end
        end
        for (int c = 0; c < G; c++) begin
            for (int i = 0; i < N; i++) begin
                in_v[i] = (r[i] >= 0) && (c >= r[i]);
            end
            cyc(in_v, rmask[c]);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        m_cnt     = 0;
        mdl_full  = 1'b0;
        exp_ovr   = 1'b0;
        pend      = '0;
        grst_n    = 1'b1;
        inputs    = '0;
        out_ready = 1'b0;
        #2;
        do_reset();

        gamma(-1, -1, -1, -1, 16'hFFFF);
        // basic decode
        gamma(3, -1, 7, -1, 16'hFFFF);
        // window edges: 13 stamped, 14 too late, held from count 0 stamps 0
        gamma(13, 14, 0, -1, 16'hFFFF);
        // backpressure: A loads, B dropped with overrun, A consumed at start of C
        gamma(-1, 5, -1, 10, 16'h0001);
        gamma(2, -1, -1, -1, 16'h0000);
        gamma(-1, -1, 9, -1, 16'h0001);
        // simultaneous accept and load at the end of D
        gamma(1, 2, 3, 4, 16'h8000);
        gamma(-1, -1, -1, -1, 16'hFFFF);

        // reset mid-gamma-cycle after line 1 fired at count 4
        for (int c = 0; c < 9; c++) begin
            cyc((c >= 4) ? 4'b0010 : 4'b0000, 1'b1);
        end
        do_reset();
        gamma(-1, -1, -1, -1, 16'hFFFF);
        gamma(-1, -1, -1, -1, 16'hFFFF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
